// File: rtl/pid_hdng_ctrl.sv
// Heading PID: three-stage pipeline turning heading error into saturated left/right wheel speeds.
// Define PID_D_TERM_EN to build the derivative path and its error history; otherwise D is zero.
module pid_hdng_ctrl #(
  parameter int HDNG_W      = 12,
  parameter int ERR_W       = 10,
  parameter int SPD_W       = 11,
  parameter int OUT_W       = 12,
  parameter int P_COEFF     = 3,
  parameter int D_COEFF     = 14,
  parameter int D_DEPTH     = 2,
  parameter int I_SHIFT     = 4,
  parameter int AT_HDNG_THR = 30
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     moving,
  input  logic                     hdng_vld,
  input  logic signed [HDNG_W-1:0] actl_hdng,
  input  logic signed [HDNG_W-1:0] dsrd_hdng,
  input  logic        [SPD_W-1:0]  frwrd_spd,
  output logic signed [OUT_W-1:0]  lft_spd,
  output logic signed [OUT_W-1:0]  rght_spd,
  output logic                     at_hdng,
  output logic                     out_vld
);

  // hdng_vld is a single-cycle sample qualifier with no backpressure; out_vld marks
  // the same sample three cycles later. Every stage recomputes each cycle.
  localparam int ERR_MAX = (1 << (ERR_W - 1)) - 1;
  localparam int ERR_MIN = -(1 << (ERR_W - 1));
  localparam int OUT_MAX = (1 << (OUT_W - 1)) - 1;
  localparam int OUT_MIN = -(1 << (OUT_W - 1));

  function automatic logic signed [OUT_W-1:0] sat_out(input int v);
    sat_out = OUT_W'(v);
    if (v > OUT_MAX)      sat_out = OUT_W'(OUT_MAX);
    else if (v < OUT_MIN) sat_out = OUT_W'(OUT_MIN);
  endfunction

  // ---------------- S0: wrapped error, saturated to ERR_W ----------------
  logic signed [HDNG_W-1:0] err_raw;
  logic signed [ERR_W-1:0]  err_sat_d, err_sat_q;
  logic                     vld_s1_q, moving_s1_q;
  logic        [SPD_W-1:0]  spd_s1_q;

  assign err_raw = actl_hdng - dsrd_hdng;

  always_comb begin
    err_sat_d = err_raw[ERR_W-1:0];
    if (int'(err_raw) > ERR_MAX)      err_sat_d = ERR_W'(ERR_MAX);
    else if (int'(err_raw) < ERR_MIN) err_sat_d = ERR_W'(ERR_MIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_sat_q   <= '0;
      vld_s1_q    <= 1'b0;
      moving_s1_q <= 1'b0;
      spd_s1_q    <= '0;
    end else begin
      err_sat_q   <= err_sat_d;
      vld_s1_q    <= hdng_vld;
      moving_s1_q <= moving;
      spd_s1_q    <= frwrd_spd;
    end
  end

  // ---------------- S1: P, D, integrator ----------------
  logic signed [15:0]      p_d, p_q, d_d, d_q;
  logic signed [15:0]      err_ext, integ_sum, integ_d, integ_q;
  logic                    integ_ovf;
  logic                    at_s2_d, at_s2_q;
  logic                    vld_s2_q, moving_s2_q;
  logic        [SPD_W-1:0] spd_s2_q;

  assign p_d = 16'(P_COEFF * int'(err_sat_q));

`ifdef PID_D_TERM_EN
  logic signed [ERR_W-1:0] hist_q [D_DEPTH];
  logic signed [ERR_W:0]   diff;
  logic signed [7:0]       diff_sat;

  assign diff = {err_sat_q[ERR_W-1], err_sat_q}
              - {hist_q[D_DEPTH-1][ERR_W-1], hist_q[D_DEPTH-1]};

  always_comb begin
    diff_sat = diff[7:0];
    if (int'(diff) > 127)       diff_sat = 8'sd127;
    else if (int'(diff) < -128) diff_sat = -8'sd128;
  end

  assign d_d = 16'(int'(diff_sat) * D_COEFF);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < D_DEPTH; i++) hist_q[i] <= '0;
    end else if (vld_s1_q) begin
      for (int i = D_DEPTH - 1; i > 0; i--) hist_q[i] <= hist_q[i-1];
      hist_q[0] <= err_sat_q;
    end
  end
`else
  // Gain and depth still shape this zero so the parameter list stays identical.
  assign d_d = 16'(D_COEFF * D_DEPTH * 0);
`endif

  assign err_ext   = {{(16 - ERR_W){err_sat_q[ERR_W-1]}}, err_sat_q};
  assign integ_sum = integ_q + err_ext;
  assign integ_ovf = (integ_q[15] == err_ext[15]) && (integ_sum[15] != integ_q[15]);

  always_comb begin
    integ_d = integ_q;
    if (!moving_s1_q)                integ_d = '0;
    else if (vld_s1_q && !integ_ovf) integ_d = integ_sum;
  end

  assign at_s2_d = (int'(err_sat_q) > -AT_HDNG_THR) && (int'(err_sat_q) < AT_HDNG_THR);

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q         <= '0;
      d_q         <= '0;
      integ_q     <= '0;
      at_s2_q     <= 1'b0;
      vld_s2_q    <= 1'b0;
      moving_s2_q <= 1'b0;
      spd_s2_q    <= '0;
    end else begin
      p_q         <= p_d;
      d_q         <= d_d;
      integ_q     <= integ_d;
      at_s2_q     <= at_s2_d;
      vld_s2_q    <= vld_s1_q;
      moving_s2_q <= moving_s1_q;
      spd_s2_q    <= spd_s1_q;
    end
  end

  // ---------------- S2: mix into wheel speeds ----------------
  logic signed [15:0]      tot, adj;
  int                      lft_wide, rght_wide;
  logic signed [OUT_W-1:0] lft_d, lft_q, rght_d, rght_q;
  logic                    at_q, vld_q;

  assign tot       = p_q + d_q + (integ_q >>> I_SHIFT);
  assign adj       = tot >>> 3;
  assign lft_wide  = int'(spd_s2_q) + int'(adj);
  assign rght_wide = int'(spd_s2_q) - int'(adj);

  always_comb begin
    lft_d  = '0;
    rght_d = '0;
    if (moving_s2_q) begin
      lft_d  = sat_out(lft_wide);
      rght_d = sat_out(rght_wide);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lft_q  <= '0;
      rght_q <= '0;
      at_q   <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      lft_q  <= lft_d;
      rght_q <= rght_d;
      at_q   <= at_s2_q;
      vld_q  <= vld_s2_q;
    end
  end

  assign lft_spd  = lft_q;
  assign rght_spd = rght_q;
  assign at_hdng  = at_q;
  assign out_vld  = vld_q;

endmodule

// File: tb/tb_pid_hdng_ctrl.sv
// Self-checking bench for pid_hdng_ctrl: sample-level scoreboard plus directed scenarios.
module tb_pid_hdng_ctrl;

  localparam int HDNG_W = 12, ERR_W = 10, SPD_W = 11, OUT_W = 12;
  localparam int P_COEFF = 3, D_COEFF = 14, D_DEPTH = 2, I_SHIFT = 4, AT_HDNG_THR = 30;
  localparam int EW = 2 * OUT_W + 2;

`ifdef PID_D_TERM_EN
  localparam int STEP_L = 290, STEP_R = 222, SATP_L = 669, SATP_R = -157;
  localparam int SATN_L = -160, SATN_R = 672, AW_L = 25, AW_R = -25;
  localparam int OS_R = 1634, WR_L = 260, WR_R = 252;
`else
  localparam int STEP_L = 262, STEP_R = 250, SATP_L = 447, SATP_R = 65;
  localparam int SATN_L = 64, SATN_R = 448, AW_L = 249, AW_R = -249;
  localparam int OS_R = 1856, WR_L = 256, WR_R = 256;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst = 1'b1;
  logic                     moving = 1'b0;
  logic                     hdng_vld = 1'b0;
  logic signed [HDNG_W-1:0] actl_hdng = '0;
  logic signed [HDNG_W-1:0] dsrd_hdng = '0;
  logic        [SPD_W-1:0]  frwrd_spd = '0;
  logic signed [OUT_W-1:0]  lft_spd, rght_spd;
  logic                     at_hdng, out_vld;

  pid_hdng_ctrl #(
    .HDNG_W(HDNG_W), .ERR_W(ERR_W), .SPD_W(SPD_W), .OUT_W(OUT_W),
    .P_COEFF(P_COEFF), .D_COEFF(D_COEFF), .D_DEPTH(D_DEPTH),
    .I_SHIFT(I_SHIFT), .AT_HDNG_THR(AT_HDNG_THR)
  ) dut (
    .clk(clk), .rst(rst), .moving(moving), .hdng_vld(hdng_vld),
    .actl_hdng(actl_hdng), .dsrd_hdng(dsrd_hdng), .frwrd_spd(frwrd_spd),
    .lft_spd(lft_spd), .rght_spd(rght_spd), .at_hdng(at_hdng), .out_vld(out_vld)
  );

  // ---------------- scoreboard ----------------
  int chk_cnt = 0;
  int pass_cnt = 0;
  int cyc = 0;
  logic [EW-1:0] exp_q[$];
  int            tgt_q[$];
  int            m_integ = 0;
  int            m_hist[D_DEPTH];

  function automatic int clip(input int v, input int lo, input int hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Reference behaviour of one input sample, evaluated in plain integer arithmetic.
  task automatic model_sample(output logic [EW-1:0] e);
    int ev, p, d, s, tot, adj, l, r;
    logic at;
    ev = int'((actl_hdng - dsrd_hdng) & 12'hFFF);
    if (ev >= 2048) ev = ev - 4096;
    ev = clip(ev, -512, 511);
    p = P_COEFF * ev;
    d = 0;
`ifdef PID_D_TERM_EN
    d = clip(ev - m_hist[D_DEPTH-1], -128, 127) * D_COEFF;
`endif
    if (hdng_vld) begin
      for (int i = D_DEPTH - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = ev;
    end
    if (!moving) m_integ = 0;
    else if (hdng_vld) begin
      s = m_integ + ev;
      if (s <= 32767 && s >= -32768) m_integ = s;
    end
    tot = p + d + (m_integ >>> I_SHIFT);
    adj = tot >>> 3;
    l = clip(int'(frwrd_spd) + adj, -2048, 2047);
    r = clip(int'(frwrd_spd) - adj, -2048, 2047);
    if (!moving) begin
      l = 0;
      r = 0;
    end
    at = (ev > -AT_HDNG_THR) && (ev < AT_HDNG_THR);
    e = {12'(l), 12'(r), at, hdng_vld};
  endtask

  // ---------------- driver ----------------
  // One clock: the model consumes the sampled inputs, then the oldest due expectation is checked.
  task automatic step();
    logic [EW-1:0] e, got;
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      tgt_q.delete();
      m_integ = 0;
      for (int i = 0; i < D_DEPTH; i++) m_hist[i] = 0;
      exp_q.push_back('0);          tgt_q.push_back(cyc);
      exp_q.push_back('0);          tgt_q.push_back(cyc + 1);
      exp_q.push_back(EW'(2'b10));  tgt_q.push_back(cyc + 2);
    end else begin
      model_sample(e);
      exp_q.push_back(e);
      tgt_q.push_back(cyc + 2);
    end
    #1;
    if (tgt_q.size() > 0 && tgt_q[0] == cyc) begin
      e = exp_q.pop_front();
      void'(tgt_q.pop_front());
      got = {lft_spd, rght_spd, at_hdng, out_vld};
      chk_cnt++;
      if (got !== e)
        $display("FAIL scoreboard cyc=%0d got lft=%0d rght=%0d at=%0b vld=%0b exp lft=%0d rght=%0d at=%0b vld=%0b",
                 cyc, lft_spd, rght_spd, at_hdng, out_vld,
                 $signed(e[EW-1:OUT_W+2]), $signed(e[OUT_W+1:2]), e[1], e[0]);
      else pass_cnt++;
    end
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    moving = 1'b0;
    hdng_vld = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic set_err(input int v);
    if (v >= 0) begin
      actl_hdng = 12'(v);
      dsrd_hdng = '0;
    end else begin
      actl_hdng = '0;
      dsrd_hdng = 12'(-v);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    chk_cnt++;
    if ({lft_spd, rght_spd, at_hdng, out_vld} !== '0)
      $display("FAIL reset_outputs got lft=%0d rght=%0d at=%0b vld=%0b exp all 0",
               lft_spd, rght_spd, at_hdng, out_vld);
    else pass_cnt++;
  endtask

  task automatic test_step();
    do_reset();
    moving = 1'b1;
    frwrd_spd = 11'h100;
    actl_hdng = 12'h010;
    dsrd_hdng = '0;
    hdng_vld = 1'b1;
    step();
    hdng_vld = 1'b0;
    step();
    step();
    chk_cnt++;
    if (lft_spd !== 12'(STEP_L) || rght_spd !== 12'(STEP_R) || out_vld !== 1'b1 || at_hdng !== 1'b1)
      $display("FAIL step_resp got lft=%0d rght=%0d vld=%0b at=%0b exp lft=%0d rght=%0d vld=1 at=1",
               lft_spd, rght_spd, out_vld, at_hdng, STEP_L, STEP_R);
    else pass_cnt++;
  endtask

  task automatic test_err_sat();
    do_reset();
    moving = 1'b1;
    frwrd_spd = 11'h100;
    actl_hdng = 12'h300;
    dsrd_hdng = '0;
    step();
    actl_hdng = '0;
    dsrd_hdng = 12'h300;
    step();
    step();
    chk_cnt++;
    if (lft_spd !== 12'(SATP_L) || rght_spd !== 12'(SATP_R))
      $display("FAIL err_sat_pos got lft=%0d rght=%0d exp lft=%0d rght=%0d", lft_spd, rght_spd, SATP_L, SATP_R);
    else pass_cnt++;
    step();
    chk_cnt++;
    if (lft_spd !== 12'(SATN_L) || rght_spd !== 12'(SATN_R))
      $display("FAIL err_sat_neg got lft=%0d rght=%0d exp lft=%0d rght=%0d", lft_spd, rght_spd, SATN_L, SATN_R);
    else pass_cnt++;
  endtask

  task automatic test_anti_windup();
    do_reset();
    moving = 1'b1;
    frwrd_spd = '0;
    set_err(511);
    hdng_vld = 1'b1;
    repeat (70) step();
    hdng_vld = 1'b0;
    repeat (3) step();
    chk_cnt++;
    if (lft_spd !== 12'sd447 || rght_spd !== -12'sd447)
      $display("FAIL windup_hold got lft=%0d rght=%0d exp lft=447 rght=-447", lft_spd, rght_spd);
    else pass_cnt++;
    set_err(-16);
    hdng_vld = 1'b1;
    step();
    hdng_vld = 1'b0;
    step();
    step();
    chk_cnt++;
    if (lft_spd !== 12'(AW_L) || rght_spd !== 12'(AW_R))
      $display("FAIL windup_release got lft=%0d rght=%0d exp lft=%0d rght=%0d", lft_spd, rght_spd, AW_L, AW_R);
    else pass_cnt++;
  endtask

  task automatic test_out_sat_and_moving();
    do_reset();
    moving = 1'b1;
    frwrd_spd = 11'h7FF;
    set_err(511);
    repeat (3) step();
    chk_cnt++;
    if (lft_spd !== 12'sd2047 || rght_spd !== 12'(OS_R))
      $display("FAIL out_sat got lft=%0d rght=%0d exp lft=2047 rght=%0d", lft_spd, rght_spd, OS_R);
    else pass_cnt++;
    hdng_vld = 1'b1;
    repeat (4) step();
    moving = 1'b0;
    step();
    moving = 1'b1;
    hdng_vld = 1'b0;
    step();
    step();
    chk_cnt++;
    if (lft_spd !== '0 || rght_spd !== '0)
      $display("FAIL moving_drop got lft=%0d rght=%0d exp 0 0", lft_spd, rght_spd);
    else pass_cnt++;
    step();
    chk_cnt++;
    if (rght_spd !== 12'sd1856)
      $display("FAIL integ_cleared got rght=%0d exp 1856", rght_spd);
    else pass_cnt++;
  endtask

  task automatic test_at_hdng();
    int  vals[4] = '{29, 30, -29, -30};
    logic exps[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    do_reset();
    moving = 1'b1;
    frwrd_spd = '0;
    for (int k = 0; k < 4; k++) begin
      set_err(vals[k]);
      repeat (3) step();
      chk_cnt++;
      if (at_hdng !== exps[k])
        $display("FAIL at_hdng err=%0d got %0b exp %0b", vals[k], at_hdng, exps[k]);
      else pass_cnt++;
    end
  endtask

  task automatic test_wrap();
    do_reset();
    moving = 1'b1;
    frwrd_spd = 11'h100;
    actl_hdng = 12'h001;
    dsrd_hdng = 12'hFFF;
    repeat (3) step();
    chk_cnt++;
    if (lft_spd !== 12'(WR_L) || rght_spd !== 12'(WR_R) || at_hdng !== 1'b1)
      $display("FAIL wrap got lft=%0d rght=%0d at=%0b exp lft=%0d rght=%0d at=1",
               lft_spd, rght_spd, at_hdng, WR_L, WR_R);
    else pass_cnt++;
  endtask

  task automatic test_rst_mid();
    do_reset();
    moving = 1'b1;
    frwrd_spd = 11'h200;
    hdng_vld = 1'b1;
    repeat (5) begin
      set_err($urandom_range(0, 200) - 100);
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_cnt++;
    if (lft_spd !== '0 || rght_spd !== '0 || at_hdng !== 1'b0 || out_vld !== 1'b0)
      $display("FAIL rst_mid got lft=%0d rght=%0d at=%0b vld=%0b exp all 0",
               lft_spd, rght_spd, at_hdng, out_vld);
    else pass_cnt++;
    repeat (4) step();
  endtask

  task automatic test_back_to_back();
    do_reset();
    repeat (400) begin
      rst       = ($urandom_range(0, 99) == 0);
      moving    = ($urandom_range(0, 15) != 0);
      hdng_vld  = 1'($urandom_range(0, 1));
      actl_hdng = 12'($urandom_range(0, 4095));
      if ($urandom_range(0, 1) == 1) dsrd_hdng = actl_hdng + 12'($urandom_range(0, 80)) - 12'd40;
      else dsrd_hdng = 12'($urandom_range(0, 4095));
      frwrd_spd = 11'($urandom_range(0, 2047));
      step();
    end
    rst = 1'b0;
    hdng_vld = 1'b0;
    repeat (4) step();
  endtask

  initial begin
    test_reset();
    test_step();
    test_err_sat();
    test_anti_windup();
    test_out_sat_and_moving();
    test_at_hdng();
    test_wrap();
    test_rst_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout after %0d cycles", cyc);
    $fatal(1, "timeout");
  end

endmodule
